// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS pipeline stages: instruction constants,
// instruction field positions, the IF stage state type and the IF/ID
// pipeline register layout.
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

    // Instruction field positions
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    typedef enum logic [1:0] {
        IF_LOAD = 2'd0,
        IF_RUN  = 2'd1,
        IF_HALT = 2'd2
    } if_state_t;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc_plus_4;
    } if_id_t;

    localparam if_id_t IF_ID_NOP = '{instruction: NOP_INSTR, pc_plus_4: 32'h0};

    // J-type target: upper PC bits of the jump's own PC+4, 26-bit word index.
    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus_4,
                                                input logic [31:0] instr);
        return {pc_plus_4[31:28], instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/if_imem.sv
// ---------------------------------------------------------------------------
// if_imem
// Word-addressed instruction memory: one synchronous write port (debug
// loader) and one asynchronous read port (fetch).
// Ports:
//   i_clk      clock
//   i_wr_en    write enable
//   i_wr_addr  write word address
//   i_wr_data  write data
//   i_rd_addr  read word address
//   o_rd_data  read data (combinational)
// ---------------------------------------------------------------------------
module if_imem #(
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [31:0]       i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [31:0]       o_rd_data
);

    logic [31:0] mem [IMEM_DEPTH];

    // NOTE: the array has no reset; clearing it would turn the RAM into a
    // large flop bank, and program contents must survive a pipeline reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the PC, the
// instruction memory and the IF/ID register; applies redirect, stall and
// flush requests from ID, and the LOAD/RUN(/HALT) debug control.
// Configuration macro: IF_HALT_EN -- when defined, fetching 32'hFFFFFFFF in
// RUN stops the stage in HALT until i_restart.
// Ports:
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_load_en/addr/data      debug write into imem (LOAD state only)
//   i_start, i_restart       LOAD->RUN, any->LOAD with PC and IF/ID cleared
//   i_step_en                RUN advance enable
//   i_stall                  hold PC and IF/ID
//   i_pc_src, i_beq_jump_dir taken branch and its target
//   i_jump                   J-type jump (target from IF/ID contents)
//   o_pc_plus_4 .. o_beq_offset  IF/ID register and its decoded fields
//   o_pc                     current PC
//   o_halted                 HALT state reached
// ---------------------------------------------------------------------------
module if_stage
    import mips_pkg::*;
#(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load_en,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [31:0]       i_load_data,
    input  logic              i_start,
    input  logic              i_restart,
    input  logic              i_step_en,
    input  logic              i_stall,
    input  logic              i_pc_src,
    input  logic [31:0]       i_beq_jump_dir,
    input  logic              i_jump,
    output logic [31:0]       o_pc_plus_4,
    output logic [31:0]       o_instruction,
    output logic [5:0]        o_opcode,
    output logic [4:0]        o_rs,
    output logic [4:0]        o_rt,
    output logic [4:0]        o_rd,
    output logic [5:0]        o_function_code,
    output logic [15:0]       o_beq_offset,
    output logic [31:0]       o_pc,
    output logic              o_halted
);

    if_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    if_id_t      if_id_q, if_id_d;
    logic [31:0] pc_next_seq;
    logic [31:0] fetched;
    logic        imem_we;

    assign pc_next_seq = pc_q + 32'd4;   // wraps modulo 2^32

    // PC[1:0] ignored; upper bits beyond the memory size wrap the address.
    if_imem #(
        .IMEM_DEPTH(IMEM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_imem (
        .i_clk    (i_clk),
        .i_wr_en  (imem_we),
        .i_wr_addr(i_load_addr),
        .i_wr_data(i_load_data),
        .i_rd_addr(pc_q[ADDR_W+1:2]),
        .o_rd_data(fetched)
    );

    // NOTE: every signal gets a default before any branch so no latch is
    // inferred when a path leaves it untouched.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if_id_d = if_id_q;
        imem_we = 1'b0;
        if (i_restart) begin
            state_d = IF_LOAD;
            pc_d    = RESET_PC;
            if_id_d = IF_ID_NOP;
        end else begin
            unique case (state_q)
                IF_LOAD: begin
                    imem_we = i_load_en;
                    if (i_start) state_d = IF_RUN;
                end
                IF_RUN: begin
                    // A stall beats a redirect; ID re-issues it next cycle.
                    if (i_step_en && !i_stall) begin
                        if (i_pc_src) begin
                            pc_d    = i_beq_jump_dir;
                            if_id_d = IF_ID_NOP;
                        end else if (i_jump) begin
                            pc_d    = jump_target(if_id_q.pc_plus_4, if_id_q.instruction);
                            if_id_d = IF_ID_NOP;
                        end else begin
                            pc_d    = pc_next_seq;
                            if_id_d = '{instruction: fetched, pc_plus_4: pc_next_seq};
`ifdef IF_HALT_EN
                            // HALT word is still passed down; PC freezes on it.
                            if (fetched == HALT_INSTR) begin
                                pc_d    = pc_q;
                                state_d = IF_HALT;
                            end
`endif
                        end
                    end
                end
                default: ;   // HALT: hold until restart
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IF_LOAD;
            pc_q    <= RESET_PC;
            if_id_q <= IF_ID_NOP;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
        end
    end

    assign o_pc            = pc_q;
    assign o_pc_plus_4     = if_id_q.pc_plus_4;
    assign o_instruction   = if_id_q.instruction;
    assign o_opcode        = if_id_q.instruction[OPCODE_MSB:OPCODE_LSB];
    assign o_rs            = if_id_q.instruction[RS_MSB:RS_LSB];
    assign o_rt            = if_id_q.instruction[RT_MSB:RT_LSB];
    assign o_rd            = if_id_q.instruction[RD_MSB:RD_LSB];
    assign o_function_code = if_id_q.instruction[FUNCT_MSB:FUNCT_LSB];
    assign o_beq_offset    = if_id_q.instruction[IMM_MSB:IMM_LSB];

`ifdef IF_HALT_EN
    assign o_halted = (state_q == IF_HALT);
`else
    assign o_halted = 1'b0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
// Directed testbench for if_stage. Inputs change 1 time unit after a rising
// edge; outputs are sampled at the same point. Halt expectations follow the
// IF_HALT_EN macro.
// ---------------------------------------------------------------------------
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset, load_en, start, restart, step_en, stall, pc_src, jump;
    logic [7:0]  load_addr;
    logic [31:0] load_data, beq_jump_dir;
    logic [31:0] pc_plus_4, instruction, pc;
    logic [5:0]  opcode, function_code;
    logic [4:0]  rs, rt, rd;
    logic [15:0] beq_offset;
    logic        halted;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [31:0] W0   = 32'h2001_0001;
    localparam logic [31:0] W1   = 32'h0022_1820;   // add $3,$1,$2
    localparam logic [31:0] W2   = 32'h1000_0005;
    localparam logic [31:0] W3   = 32'h3C01_1234;
    localparam logic [31:0] W4   = 32'h0800_0010;   // j index 0x10
    localparam logic [31:0] W16  = 32'h8C22_0004;
    localparam logic [31:0] W17  = 32'hAC23_0008;
    localparam logic [31:0] W32  = 32'h1234_5678;
    localparam logic [31:0] W255 = 32'hCAFE_0001;

    always #5 clk = ~clk;

    if_stage dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_load_en      (load_en),
        .i_load_addr    (load_addr),
        .i_load_data    (load_data),
        .i_start        (start),
        .i_restart      (restart),
        .i_step_en      (step_en),
        .i_stall        (stall),
        .i_pc_src       (pc_src),
        .i_beq_jump_dir (beq_jump_dir),
        .i_jump         (jump),
        .o_pc_plus_4    (pc_plus_4),
        .o_instruction  (instruction),
        .o_opcode       (opcode),
        .o_rs           (rs),
        .o_rt           (rt),
        .o_rd           (rd),
        .o_function_code(function_code),
        .o_beq_offset   (beq_offset),
        .o_pc           (pc),
        .o_halted       (halted)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] addr, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] exp_instr,
                              input logic [31:0] exp_pp4, input logic [31:0] exp_pc);
        check({tag, ".instr"}, instruction, exp_instr);
        check({tag, ".pp4"},   pc_plus_4,   exp_pp4);
        check({tag, ".pc"},    pc,          exp_pc);
    endtask

    task automatic restart_and_start();
        restart = 1'b1; tick(); restart = 1'b0;
        start   = 1'b1; tick(); start   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load_en = 1'b0; start = 1'b0; restart = 1'b0;
        step_en = 1'b1; stall = 1'b0; pc_src = 1'b0; jump = 1'b0;
        load_addr = '0; load_data = '0; beq_jump_dir = '0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        check_ifid("reset", 32'h0, 32'h0, 32'h0);
        check("reset.halted", {31'b0, halted}, 32'h0);

        // Program load; PC and IF/ID hold in LOAD
        load(8'd0, W0);   load(8'd1, W1);   load(8'd2, W2);   load(8'd3, W3);
        load(8'd4, W4);   load(8'd16, W16); load(8'd17, W17); load(8'd32, W32);
        load(8'd255, W255);
        check_ifid("load_hold", 32'h0, 32'h0, 32'h0);

        // Start: state change only on this edge
        start = 1'b1; tick(); start = 1'b0;
        check_ifid("start", 32'h0, 32'h0, 32'h0);

        // Sequential fetch
        tick(); check_ifid("seq0", W0, 32'd4, 32'd4);
        tick(); check_ifid("seq1", W1, 32'd8, 32'd8);
        check("f.opcode", {26'b0, opcode}, 32'h0);
        check("f.rs",     {27'b0, rs}, 32'd1);
        check("f.rt",     {27'b0, rt}, 32'd2);
        check("f.rd",     {27'b0, rd}, 32'd3);
        check("f.funct",  {26'b0, function_code}, 32'h20);
        check("f.offset", {16'b0, beq_offset}, 32'h1820);

        // Two-cycle stall at PC=8; second cycle also carries a branch (stall wins)
        stall = 1'b1; tick();
        check_ifid("stall1", W1, 32'd8, 32'd8);
        pc_src = 1'b1; beq_jump_dir = 32'h80; tick();
        check_ifid("stall2_br", W1, 32'd8, 32'd8);
        stall = 1'b0; pc_src = 1'b0; tick();
        check_ifid("unstall", W2, 32'd12, 32'd12);

        // Step disabled: everything holds
        step_en = 1'b0; tick();
        check_ifid("step_off", W2, 32'd12, 32'd12);
        step_en = 1'b1; tick();
        check_ifid("seq3", W3, 32'd16, 32'd16);

        // Taken branch to 0x40 at PC=16
        pc_src = 1'b1; beq_jump_dir = 32'h40; tick(); pc_src = 1'b0;
        check_ifid("br_flush", 32'h0, 32'h0, 32'h40);
        tick(); check_ifid("br_target", W16, 32'h44, 32'h44);

        // Get J into IF/ID (pp4=0x14), then jump
        pc_src = 1'b1; beq_jump_dir = 32'h10; tick(); pc_src = 1'b0;
        tick(); check_ifid("j_in_ifid", W4, 32'h14, 32'h14);
        jump = 1'b1; tick(); jump = 1'b0;
        check_ifid("jump_flush", 32'h0, 32'h0, 32'h40);
        tick(); check_ifid("jump_target", W16, 32'h44, 32'h44);

        // pc_src and jump together: branch target wins
        pc_src = 1'b1; beq_jump_dir = 32'h10; tick(); pc_src = 1'b0;
        tick();
        pc_src = 1'b1; jump = 1'b1; beq_jump_dir = 32'h80; tick();
        pc_src = 1'b0; jump = 1'b0;
        check_ifid("br_and_j", 32'h0, 32'h0, 32'h80);
        tick(); check_ifid("br_and_j_tgt", W32, 32'h84, 32'h84);

        // Load while running is ignored
        step_en = 1'b0; load(8'd0, 32'hDEAD_BEEF); step_en = 1'b1;
        restart = 1'b1; tick(); restart = 1'b0;
        check_ifid("restart", 32'h0, 32'h0, 32'h0);
        start = 1'b1; tick(); start = 1'b0;
        tick(); check_ifid("run_load_ign", W0, 32'd4, 32'd4);

        // PC wrap: branch to 0xFFFFFFFC reads word 255, PC+4 wraps to 0
        pc_src = 1'b1; beq_jump_dir = 32'hFFFF_FFFC; tick(); pc_src = 1'b0;
        check("wrap.pc", pc, 32'hFFFF_FFFC);
        tick(); check_ifid("wrap", W255, 32'h0, 32'h0);

        // Halt word at word 3
        restart = 1'b1; tick(); restart = 1'b0;
        load(8'd3, 32'hFFFF_FFFF);
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        check_ifid("pre_halt", W2, 32'd12, 32'd12);
        tick();
`ifdef IF_HALT_EN
        check_ifid("halt", 32'hFFFF_FFFF, 32'd16, 32'd12);
        check("halt.halted", {31'b0, halted}, 32'd1);
        tick();
        check_ifid("halt_hold", 32'hFFFF_FFFF, 32'd16, 32'd12);
        check("halt_hold.halted", {31'b0, halted}, 32'd1);
`else
        check_ifid("ffff_plain", 32'hFFFF_FFFF, 32'd16, 32'd16);
        check("ffff.halted", {31'b0, halted}, 32'd0);
        tick();
        check_ifid("after_ffff", W4, 32'd20, 32'd20);
`endif
        restart = 1'b1; tick(); restart = 1'b0;
        check_ifid("restart2", 32'h0, 32'h0, 32'h0);
        check("restart2.halted", {31'b0, halted}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
